// File: rtl/gt_operand_loader.sv
// Switch/button front-end for the 2-bit greater-than comparator: synchronize, debounce, capture on press.
// Optional build macro GT_AUTO_LOAD_EN: also capture in IDLE whenever the debounced switches differ from a_q/b_q.
module gt_operand_loader #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sw,
  input  logic       btn_load,
  output logic [1:0] a_q,
  output logic [1:0] b_q,
  output logic       op_valid,
  output logic       loaded
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    IDLE,
    HOLD
  } state_t;

  // Bit 4 carries the button, bits 3:0 the switches, through every stage.
  logic [4:0]    sync_q [SYNC_STAGES];
  logic [4:0]    synced;
  logic [4:0]    db_q;
  logic [CW-1:0] cnt_q  [5];
  logic          db_btn;
  logic [3:0]    db_sw;
  state_t        state_q;
  state_t        state_d;
  logic          capture;

  assign synced = sync_q[SYNC_STAGES-1];
  assign db_btn = db_q[4];
  assign db_sw  = db_q[3:0];

  // Stage boundary: raw asynchronous inputs -> synchronizer chain
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= {btn_load, sw};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // Stage boundary: synchronized bits -> debounced bits
  always_ff @(posedge clk) begin
    if (rst) begin
      db_q <= '0;
      for (int i = 0; i < 5; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (synced[i] == db_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          db_q[i]  <= ~db_q[i];
          cnt_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + CW'(1);
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (db_btn) begin
          capture = 1'b1;
          state_d = HOLD;
        end
`ifdef GT_AUTO_LOAD_EN
        else if (db_sw != {a_q, b_q}) begin
          capture = 1'b1;
        end
`endif
      end
      HOLD: begin
        if (!db_btn) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Stage boundary: debounced values -> captured operand registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_valid <= 1'b0;
      loaded   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_valid <= capture;
      if (capture) begin
        a_q    <= db_sw[3:2];
        b_q    <= db_sw[1:0];
        loaded <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_gt_operand_loader.sv
// Scoreboard bench for gt_operand_loader with DEBOUNCE_CYCLES=4, SYNC_STAGES=2.
// Inputs are driven on the falling edge; a pulse for a press driven at cycle c is expected high in cycle c+7.
module tb_gt_operand_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] sw = 4'b0000;
  logic       btn_load = 1'b0;
  logic [1:0] a_q;
  logic [1:0] b_q;
  logic       op_valid;
  logic       loaded;

  gt_operand_loader #(
    .DEBOUNCE_CYCLES(4),
    .SYNC_STAGES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sw(sw),
    .btn_load(btn_load),
    .a_q(a_q),
    .b_q(b_q),
    .op_valid(op_valid),
    .loaded(loaded)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0] a;
    logic [1:0] b;
    int         at;
  } exp_t;

  exp_t sbq[$];
  int   tests = 0;
  int   fails = 0;
  logic prev_vld = 1'b0;

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_pulse(input logic [1:0] a, input logic [1:0] b, input int at);
    exp_t e;
    e.a  = a;
    e.b  = b;
    e.at = at;
    sbq.push_back(e);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_a_q"}, int'(a_q), 0);
    check({tag, "_b_q"}, int'(b_q), 0);
    check({tag, "_op_valid"}, int'(op_valid), 0);
    check({tag, "_loaded"}, int'(loaded), 0);
  endtask

  // Monitor: every op_valid pulse must match the oldest expectation in pair and timing.
  always @(negedge clk) begin
    exp_t e;
    if (op_valid) begin
      check("op_valid_consecutive", int'(prev_vld), 0);
      check("pulse_expected", int'(sbq.size() != 0), 1);
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        check("pulse_pair", int'({a_q, b_q}), int'({e.a, e.b}));
        check("pulse_cycle", cyc, e.at);
      end
    end
    prev_vld = op_valid;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    tick(1);
    do_reset();
    check_cleared("reset");

`ifdef GT_AUTO_LOAD_EN
    // Auto capture: switches alone trigger one pulse per debounced change.
    tick(5);
    sw = 4'b0110;
    expect_pulse(2'b01, 2'b10, cyc + 7);
    tick(30);
    check("auto_a_q", int'(a_q), 1);
    check("auto_b_q", int'(b_q), 2);
    check("auto_loaded", int'(loaded), 1);
    sw = 4'b1111;
    expect_pulse(2'b11, 2'b11, cyc + 7);
    tick(30);
    check("auto2_a_q", int'(a_q), 3);
`else
    // Stable switches, button held: one capture of 10/01.
    sw = 4'b1001;
    tick(10);
    btn_load = 1'b1;
    expect_pulse(2'b10, 2'b01, cyc + 7);
    tick(8);
    check("t1_loaded", int'(loaded), 1);
    check("t1_a_q", int'(a_q), 2);
    check("t1_b_q", int'(b_q), 1);

    // Long hold with a switch change underneath: no second pulse, operands frozen.
    tick(20);
    sw = 4'b0111;
    tick(30);
    btn_load = 1'b0;
    tick(15);
    check("t2_a_q", int'(a_q), 2);
    check("t2_b_q", int'(b_q), 1);

    // Three-cycle glitch after reset is filtered.
    sw = 4'b1001;
    do_reset();
    tick(10);
    btn_load = 1'b1;
    tick(3);
    btn_load = 1'b0;
    tick(20);
    check_cleared("t3");

    // Switch debounce finishing on the capture edge contributes its old value.
    sw = 4'b0000;
    do_reset();
    tick(10);
    btn_load = 1'b1;
    expect_pulse(2'b00, 2'b00, cyc + 7);
    tick(1);
    sw = 4'b1100;
    tick(20);
    btn_load = 1'b0;
    tick(15);
    check("t4_loaded", int'(loaded), 1);
    check("t4_a_q_first", int'(a_q), 0);
    btn_load = 1'b1;
    expect_pulse(2'b11, 2'b00, cyc + 7);
    tick(20);
    btn_load = 1'b0;
    tick(15);
    check("t4_a_q_second", int'(a_q), 3);

    // Reset while in HOLD with the button still held: clear, then one fresh capture.
    sw = 4'b1001;
    tick(15);
    btn_load = 1'b1;
    expect_pulse(2'b10, 2'b01, cyc + 7);
    tick(20);
    check("t5_hold_a_q", int'(a_q), 2);
    rst = 1'b1;
    tick(1);
    check_cleared("t5_reset");
    rst = 1'b0;
    expect_pulse(2'b10, 2'b01, cyc + 7);
    tick(20);
    check("t5_reload_loaded", int'(loaded), 1);
    btn_load = 1'b0;
    tick(15);

    // Without the auto-load feature a switch change alone never captures.
    sw = 4'b0110;
    tick(20);
    check("no_auto_pair", int'({a_q, b_q}), int'(4'b1001));
`endif

    tick(2);
    check("scoreboard_drained", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
